// File: rtl/biriscv_compress_if.sv
// biriscv_compress_if
//   Groups the instruction input handshake, the packed code-word output
//   handshake, flush request and status outputs of the RVC compressor.
//   Signal names keep the block-level direction suffixes so the bus maps
//   one-to-one onto the compressor's external pins.
//
//   in_valid_i / in_instr_i / in_ready_o : 32-bit instruction offer
//   flush_i                               : request to emit a held half-word
//   out_valid_o / out_word_o / out_ready_i: packed 32-bit code word
//   idle_o                                : nothing held, nothing pending
//   count_o                               : saturating compressed count
interface biriscv_compress_if;
    logic        in_valid_i;
    logic [31:0] in_instr_i;
    logic        in_ready_o;
    logic        flush_i;
    logic        out_valid_o;
    logic [31:0] out_word_o;
    logic        out_ready_i;
    logic        idle_o;
    logic [15:0] count_o;

    // Compressor side
    modport slave (
        input  in_valid_i,
        input  in_instr_i,
        input  flush_i,
        input  out_ready_i,
        output in_ready_o,
        output out_valid_o,
        output out_word_o,
        output idle_o,
        output count_o
    );

    // Producer / consumer side
    modport master (
        output in_valid_i,
        output in_instr_i,
        output flush_i,
        output out_ready_i,
        input  in_ready_o,
        input  out_valid_o,
        input  out_word_o,
        input  idle_o,
        input  count_o
    );
endinterface

// File: rtl/biriscv_compress.sv
// biriscv_compress
//   Converts a stream of RV32I instructions into a dense stream of 32-bit
//   code words. Instructions that have a compact RVC form (C.LWSP, C.SWSP,
//   C.LW, C.SW, C.J, C.JAL, C.JR, C.JALR, C.BEQZ, C.BNEZ) are shrunk to 16
//   bits; everything else passes through unchanged. Parcels are packed
//   little-end first: bits [15:0] of an output word are the earlier parcel.
//   A single 16-bit hold register carries a leftover parcel between words.
//
//   clk_i  : clock, rising edge
//   rst_ni : asynchronous active-low reset
//   bus    : biriscv_compress_if.slave (input handshake, output handshake,
//            flush request, idle flag, saturating compressed-instruction count)
module biriscv_compress (
    input  logic              clk_i,
    input  logic              rst_ni,
    biriscv_compress_if.slave bus
);

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_HALF  = 1'b1
    } state_t;

    localparam logic [15:0] C_NOP = 16'h0001;

    // Returns {compressible, rvc_parcel}. The parcel is zero when the
    // instruction has no compact form. Checks are ordered so the stack-
    // pointer forms win over the register-window forms.
    function automatic logic [16:0] compress_fn(input logic [31:0] instr);
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [11:0] imm_i;
        logic [11:0] imm_s;
        logic [20:0] imm_j;
        logic [12:0] imm_b;
        logic        is_lw;
        logic        is_sw;
        logic        rd_c;
        logic        rs1_c;
        logic        rs2_c;
        logic [16:0] res;
        op    = instr[6:0];
        f3    = instr[14:12];
        rd    = instr[11:7];
        rs1   = instr[19:15];
        rs2   = instr[24:20];
        imm_i = instr[31:20];
        imm_s = {instr[31:25], instr[11:7]};
        imm_j = {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
        imm_b = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
        is_lw = (op == 7'b0000011) && (f3 == 3'b010);
        is_sw = (op == 7'b0100011) && (f3 == 3'b010);
        // x8..x15 are the registers reachable through a 3-bit field
        rd_c  = (rd[4:3] == 2'b01);
        rs1_c = (rs1[4:3] == 2'b01);
        rs2_c = (rs2[4:3] == 2'b01);

        if (is_lw && (rs1 == 5'd2) && (rd != 5'd0) &&
            (imm_i[11:8] == 4'd0) && (imm_i[1:0] == 2'd0)) begin
            res = {1'b1, 3'b010, imm_i[5], rd, imm_i[4:2], imm_i[7:6], 2'b10};
        end else if (is_sw && (rs1 == 5'd2) &&
                     (imm_s[11:8] == 4'd0) && (imm_s[1:0] == 2'd0)) begin
            res = {1'b1, 3'b110, imm_s[5:2], imm_s[7:6], rs2, 2'b10};
        end else if (is_lw && rd_c && rs1_c &&
                     (imm_i[11:7] == 5'd0) && (imm_i[1:0] == 2'd0)) begin
            res = {1'b1, 3'b010, imm_i[5:3], rs1[2:0], imm_i[2], imm_i[6],
                   rd[2:0], 2'b00};
        end else if (is_sw && rs2_c && rs1_c &&
                     (imm_s[11:7] == 5'd0) && (imm_s[1:0] == 2'd0)) begin
            res = {1'b1, 3'b110, imm_s[5:3], rs1[2:0], imm_s[2], imm_s[6],
                   rs2[2:0], 2'b00};
        end else if ((op == 7'b1101111) && (rd[4:1] == 4'd0) &&
                     ((imm_j[20:11] == 10'h000) || (imm_j[20:11] == 10'h3FF))) begin
            // Offset fits in 12 signed bits when its top bits are a pure sign extension
            res = {1'b1, (rd[0] ? 3'b001 : 3'b101), imm_j[11], imm_j[4],
                   imm_j[9:8], imm_j[10], imm_j[6], imm_j[7], imm_j[3:1],
                   imm_j[5], 2'b01};
        end else if ((op == 7'b1100111) && (f3 == 3'b000) && (rd[4:1] == 4'd0) &&
                     (rs1 != 5'd0) && (imm_i == 12'd0)) begin
            res = {1'b1, 3'b100, rd[0], rs1, 5'd0, 2'b10};
        end else if ((op == 7'b1100011) && (f3[2:1] == 2'b00) && (rs2 == 5'd0) &&
                     rs1_c && ((imm_b[12:8] == 5'h00) || (imm_b[12:8] == 5'h1F))) begin
            res = {1'b1, (f3[0] ? 3'b111 : 3'b110), imm_b[8], imm_b[4:3],
                   rs1[2:0], imm_b[7:6], imm_b[2:1], imm_b[5], 2'b01};
        end else begin
            res = {1'b0, 16'h0000};
        end
        return res;
    endfunction

    state_t      state_r;
    state_t      state_nxt_s;
    logic [15:0] hold_r;
    logic [15:0] hold_nxt_s;
    logic        out_valid_r;
    logic        out_valid_nxt_s;
    logic [31:0] out_word_r;
    logic [31:0] out_word_nxt_s;
    logic [15:0] count_r;
    logic [15:0] count_nxt_s;

    logic        slot_free_s;
    logic        in_ready_s;
    logic        accept_s;
    logic        flush_fire_s;
    logic [16:0] comp_s;
    logic        is16_s;
    logic [15:0] c16_s;

    // Output slot can take a new word when empty or being drained this cycle
    assign slot_free_s  = !out_valid_r || bus.out_ready_i;
    assign in_ready_s   = !bus.flush_i && slot_free_s;
    assign accept_s     = bus.in_valid_i && in_ready_s;
    assign flush_fire_s = bus.flush_i && (state_r == ST_HALF) && slot_free_s;
    assign comp_s       = compress_fn(bus.in_instr_i);
    assign is16_s       = comp_s[16];
    assign c16_s        = comp_s[15:0];

    // Next-state, packing and counter logic
    always_comb begin
        state_nxt_s     = state_r;
        hold_nxt_s      = hold_r;
        out_valid_nxt_s = out_valid_r && !bus.out_ready_i;
        out_word_nxt_s  = out_word_r;
        count_nxt_s     = count_r;
        if (accept_s) begin
            case (state_r)
                ST_EMPTY: begin
                    if (is16_s) begin
                        hold_nxt_s  = c16_s;
                        state_nxt_s = ST_HALF;
                    end else begin
                        out_valid_nxt_s = 1'b1;
                        out_word_nxt_s  = bus.in_instr_i;
                    end
                end
                ST_HALF: begin
                    out_valid_nxt_s = 1'b1;
                    if (is16_s) begin
                        out_word_nxt_s = {c16_s, hold_r};
                        hold_nxt_s     = 16'h0000;
                        state_nxt_s    = ST_EMPTY;
                    end else begin
                        // A 32-bit instruction straddles the word boundary
                        out_word_nxt_s = {bus.in_instr_i[15:0], hold_r};
                        hold_nxt_s     = bus.in_instr_i[31:16];
                    end
                end
                default: begin
                    hold_nxt_s  = 16'h0000;
                    state_nxt_s = ST_EMPTY;
                end
            endcase
            if (is16_s && (count_r != 16'hFFFF)) begin
                count_nxt_s = count_r + 16'd1;
            end else begin
                count_nxt_s = count_r;
            end
        end else if (flush_fire_s) begin
            // Pad the leftover parcel with a C.NOP so the word is complete
            out_valid_nxt_s = 1'b1;
            out_word_nxt_s  = {C_NOP, hold_r};
            hold_nxt_s      = 16'h0000;
            state_nxt_s     = ST_EMPTY;
        end else begin
            hold_nxt_s  = hold_r;
            state_nxt_s = state_r;
        end
    end

    // State, hold parcel, output slot and counter registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r     <= ST_EMPTY;
            hold_r      <= 16'h0000;
            out_valid_r <= 1'b0;
            out_word_r  <= 32'h0000_0000;
            count_r     <= 16'h0000;
        end else begin
            state_r     <= state_nxt_s;
            hold_r      <= hold_nxt_s;
            out_valid_r <= out_valid_nxt_s;
            out_word_r  <= out_word_nxt_s;
            count_r     <= count_nxt_s;
        end
    end

    assign bus.in_ready_o  = in_ready_s;
    assign bus.out_valid_o = out_valid_r;
    assign bus.out_word_o  = out_word_r;
    assign bus.count_o     = count_r;
    assign bus.idle_o      = (state_r == ST_EMPTY) && !out_valid_r;

endmodule

// File: tb/tb_biriscv_compress.sv
module tb_biriscv_compress;

    logic clk = 1'b0;
    logic rst_ni;
    biriscv_compress_if bus();

    biriscv_compress dut (
        .clk_i  (clk),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // behavioural model state
    bit          m_valid;
    logic [31:0] m_word;
    bit          m_half;
    logic [15:0] m_held;
    int          m_count;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference compressor written from the instruction-level rules with integers.
    task automatic bm_compress(input logic [31:0] i, output bit is16, output logic [15:0] c);
        int op, f3, rd, rs1, rs2, immi, imms, immb, immj;
        logic signed [11:0] si, ss;
        logic signed [12:0] sb;
        logic signed [20:0] sj;
        logic [31:0] u;
        op = i[6:0]; f3 = i[14:12]; rd = i[11:7]; rs1 = i[19:15]; rs2 = i[24:20];
        si = i[31:20]; ss = {i[31:25], i[11:7]};
        sb = {i[31], i[7], i[30:25], i[11:8], 1'b0};
        sj = {i[31], i[19:12], i[20], i[30:21], 1'b0};
        immi = si; imms = ss; immb = sb; immj = sj;
        is16 = 1'b1; c = 16'h0000;
        if (op == 3 && f3 == 2 && rs1 == 2 && rd != 0 && immi >= 0 && immi <= 252 && immi % 4 == 0) begin
            u = immi; c = {3'b010, u[5], i[11:7], u[4:2], u[7:6], 2'b10};
        end else if (op == 35 && f3 == 2 && rs1 == 2 && imms >= 0 && imms <= 252 && imms % 4 == 0) begin
            u = imms; c = {3'b110, u[5:2], u[7:6], i[24:20], 2'b10};
        end else if (op == 3 && f3 == 2 && rd >= 8 && rd <= 15 && rs1 >= 8 && rs1 <= 15 &&
                     immi >= 0 && immi <= 124 && immi % 4 == 0) begin
            u = immi; c = {3'b010, u[5:3], i[17:15], u[2], u[6], i[9:7], 2'b00};
        end else if (op == 35 && f3 == 2 && rs2 >= 8 && rs2 <= 15 && rs1 >= 8 && rs1 <= 15 &&
                     imms >= 0 && imms <= 124 && imms % 4 == 0) begin
            u = imms; c = {3'b110, u[5:3], i[17:15], u[2], u[6], i[22:20], 2'b00};
        end else if (op == 111 && (rd == 0 || rd == 1) && immj >= -2048 && immj <= 2046) begin
            u = immj;
            c = {(rd == 1) ? 3'b001 : 3'b101, u[11], u[4], u[9:8], u[10], u[6], u[7], u[3:1], u[5], 2'b01};
        end else if (op == 103 && f3 == 0 && (rd == 0 || rd == 1) && rs1 != 0 && immi == 0) begin
            c = {3'b100, (rd == 1) ? 1'b1 : 1'b0, i[19:15], 5'd0, 2'b10};
        end else if (op == 99 && (f3 == 0 || f3 == 1) && rs2 == 0 && rs1 >= 8 && rs1 <= 15 &&
                     immb >= -256 && immb <= 254) begin
            u = immb;
            c = {(f3 == 1) ? 3'b111 : 3'b110, u[8], u[4:3], i[17:15], u[7:6], u[2:1], u[5], 2'b01};
        end else begin
            is16 = 1'b0;
        end
    endtask

    task automatic model_reset();
        m_valid = 0; m_word = 32'h0; m_half = 0; m_held = 16'h0; m_count = 0;
    endtask

    // One clock of the reference behaviour, using the inputs about to be sampled.
    task automatic model_step();
        bit free, acc, is16;
        logic [15:0] c;
        free = !m_valid || bus.out_ready_i;
        acc  = bus.in_valid_i && !bus.flush_i && free;
        if (m_valid && bus.out_ready_i) m_valid = 0;
        if (acc) begin
            bm_compress(bus.in_instr_i, is16, c);
            if (is16 && m_count < 65535) m_count++;
            if (!m_half) begin
                if (is16) begin m_held = c; m_half = 1; end
                else begin m_valid = 1; m_word = bus.in_instr_i; end
            end else begin
                m_valid = 1;
                if (is16) begin m_word = {c, m_held}; m_half = 0; end
                else begin m_word = {bus.in_instr_i[15:0], m_held}; m_held = bus.in_instr_i[31:16]; end
            end
        end else if (bus.flush_i && m_half && free) begin
            m_valid = 1; m_word = {16'h0001, m_held}; m_half = 0;
        end
    endtask

    task automatic monitor_cycle();
        @(negedge clk);
        if (!rst_ni) model_reset();
        chk("out_valid", {31'h0, bus.out_valid_o}, {31'h0, m_valid});
        if (m_valid || !rst_ni) chk("out_word", bus.out_word_o, m_word);
        chk("in_ready", {31'h0, bus.in_ready_o}, {31'h0, (!bus.flush_i && (!m_valid || bus.out_ready_i))});
        chk("idle", {31'h0, bus.idle_o}, {31'h0, (!m_half && !m_valid)});
        chk("count", {16'h0, bus.count_o}, m_count);
        if (rst_ni) model_step();
    endtask

    task automatic send(input logic [31:0] ins);
        bit ok;
        ok = 0;
        bus.in_valid_i = 1'b1; bus.in_instr_i = ins;
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge clk); ok = bus.in_ready_o;
            @(posedge clk); #1;
        end
        bus.in_valid_i = 1'b0;
        if (!ok) begin
            n_checks++; n_fail++;
            $display("FAIL send_timeout: instr %h never accepted", ins);
        end
    endtask

    task automatic wait_valid(input string name, input logic [31:0] exp);
        bit seen;
        seen = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk); seen = bus.out_valid_o;
        end
        if (!seen) begin
            n_checks++; n_fail++;
            $display("FAIL %s: out_valid never rose, expected word %h", name, exp);
        end else begin
            chk(name, bus.out_word_o, exp);
        end
    endtask

    task automatic step_cyc();
        @(posedge clk); #1;
    endtask

    function automatic logic [4:0] pick_reg();
        int r;
        r = $urandom_range(0, 9);
        if (r < 5) return 5'(8 + $urandom_range(0, 7));
        else if (r < 7) return 5'd2;
        else return 5'($urandom_range(0, 31));
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] t, o;
        logic [4:0] rd, rs1, rs2;
        int k, v;
        k = $urandom_range(0, 6);
        rd = pick_reg(); rs1 = pick_reg(); rs2 = pick_reg();
        if ($urandom_range(0, 3) == 0) v = $urandom_range(0, 4095) - 2048;
        else v = $urandom_range(0, 70) * 4 - 8;
        t = v;
        case (k)
            0: return {t[11:0], rs1, 3'b010, rd, 7'b0000011};
            1: return {t[11:5], rs2, rs1, 3'b010, t[4:0], 7'b0100011};
            2: begin
                v = ($urandom_range(0, 2400) - 1200) * 2; o = v;
                rd = 5'($urandom_range(0, 2));
                return {o[20], o[10:1], o[11], o[19:12], rd, 7'b1101111};
            end
            3: begin
                rd = 5'($urandom_range(0, 2));
                t = ($urandom_range(0, 3) == 0) ? 32'd4 : 32'd0;
                if ($urandom_range(0, 4) == 0) rs1 = 5'd0;
                return {t[11:0], rs1, 3'b000, rd, 7'b1100111};
            end
            4: begin
                v = ($urandom_range(0, 300) - 150) * 2; o = v;
                rs2 = ($urandom_range(0, 3) == 0) ? pick_reg() : 5'd0;
                return {o[12], o[10:5], rs2, rs1, 2'b00, 1'($urandom_range(0, 1)), o[4:1], o[11], 7'b1100011};
            end
            5: return $urandom;
            default: begin
                t = $urandom;
                t[1:0] = 2'($urandom_range(0, 2));
                return t;
            end
        endcase
    endfunction

    initial begin
        bit is16;
        logic [15:0] c;
        rst_ni = 1'b0;
        bus.in_valid_i = 1'b0; bus.in_instr_i = 32'h0;
        bus.flush_i = 1'b0; bus.out_ready_i = 1'b1;
        model_reset();

        fork
            forever monitor_cycle();
        join_none

        // pin the reference compressor to hand-encoded parcels
        bm_compress(32'h0044A403, is16, c); chk("pin_c_lw", {15'h0, is16, c}, 32'h0001_40C0);
        bm_compress(32'h00008067, is16, c); chk("pin_c_jr", {15'h0, is16, c}, 32'h0001_8082);
        bm_compress(32'h003100B3, is16, c); chk("pin_add", {31'h0, is16}, 32'h0);
        bm_compress(32'hF00400E3, is16, c); chk("pin_beqz_m256", {15'h0, is16, c}, 32'h0001_D001);
        bm_compress(32'h10040063, is16, c); chk("pin_beq_p256", {31'h0, is16}, 32'h0);

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_idle", {31'h0, bus.idle_o}, 32'h1);
        chk("rst_count", {16'h0, bus.count_o}, 32'h0);
        chk("rst_valid", {31'h0, bus.out_valid_o}, 32'h0);
        @(posedge clk); #1 rst_ni = 1'b1;
        step_cyc();

        // two compressed halves pack into one word
        send(32'h0044A403);
        send(32'h00008067);
        wait_valid("pair_word", 32'h808240C0);
        chk("pair_count", {16'h0, bus.count_o}, 32'd2);
        @(negedge clk); @(negedge clk);
        chk("pair_idle", {31'h0, bus.idle_o}, 32'h1);
        step_cyc();

        // uncompressible instruction passes straight through
        send(32'h003100B3);
        wait_valid("pass_word", 32'h003100B3);
        chk("pass_count", {16'h0, bus.count_o}, 32'd2);
        step_cyc();

        // straddling 32-bit instruction, then flush the leftover half
        send(32'h0044A403);
        send(32'h003100B3);
        wait_valid("straddle_word", 32'h00B340C0);
        step_cyc();
        bus.flush_i = 1'b1;
        step_cyc();
        bus.flush_i = 1'b0;
        wait_valid("flush_word", 32'h00010031);
        @(negedge clk); @(negedge clk);
        chk("flush_idle", {31'h0, bus.idle_o}, 32'h1);
        step_cyc();

        // back-pressure: word held stable, next input waits
        bus.out_ready_i = 1'b0;
        send(32'h003100B3);
        bus.in_valid_i = 1'b1; bus.in_instr_i = 32'h00B00093;
        repeat (5) begin
            @(negedge clk);
            chk("stall_word", bus.out_word_o, 32'h003100B3);
            chk("stall_ready", {31'h0, bus.in_ready_o}, 32'h0);
        end
        step_cyc();
        bus.out_ready_i = 1'b1;
        @(negedge clk);
        chk("release_ready", {31'h0, bus.in_ready_o}, 32'h1);
        step_cyc();
        bus.in_valid_i = 1'b0;
        @(negedge clk);
        chk("release_word", bus.out_word_o, 32'h00B00093);
        step_cyc();

        // reset while a half-word is held
        send(32'h0044A403);
        rst_ni = 1'b0;
        @(negedge clk);
        chk("midrst_idle", {31'h0, bus.idle_o}, 32'h1);
        chk("midrst_word", bus.out_word_o, 32'h0);
        step_cyc();
        rst_ni = 1'b1;
        bus.flush_i = 1'b1;
        repeat (3) step_cyc();
        bus.flush_i = 1'b0;
        @(negedge clk);
        chk("midrst_no_stale", {31'h0, bus.out_valid_o}, 32'h0);
        step_cyc();

        // range boundaries
        send(32'h00012003); wait_valid("bnd_lw_x0", 32'h00012003); step_cyc();
        send(32'h0804A403); wait_valid("bnd_lw_128", 32'h0804A403); step_cyc();
        send(32'h10040063); wait_valid("bnd_beq_p256", 32'h10040063); step_cyc();
        send(32'hF00400E3);
        bus.flush_i = 1'b1; step_cyc(); bus.flush_i = 1'b0;
        wait_valid("bnd_beqz_m256", 32'h0001D001);
        step_cyc();

        // randomized traffic against the model, with occasional resets
        for (int n = 0; n < 4000; n++) begin
            bus.in_valid_i  = ($urandom_range(0, 9) < 6);
            bus.in_instr_i  = rand_instr();
            bus.flush_i     = ($urandom_range(0, 9) == 0);
            bus.out_ready_i = ($urandom_range(0, 9) < 7);
            rst_ni          = ($urandom_range(0, 299) != 0);
            step_cyc();
        end
        bus.in_valid_i = 1'b0; bus.flush_i = 1'b0; bus.out_ready_i = 1'b1;
        rst_ni = 1'b0; step_cyc(); rst_ni = 1'b1; step_cyc();

        // counter saturation
        bus.in_valid_i = 1'b1; bus.in_instr_i = 32'h0044A403;
        repeat (65540) @(posedge clk);
        #1 bus.in_valid_i = 1'b0;
        @(negedge clk);
        chk("count_sat", {16'h0, bus.count_o}, 32'h0000FFFF);
        repeat (3) step_cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/biriscv_compress.md
BIRISCV_COMPRESS -- requirements
Module: biriscv_compress

Interface
REQ-001 SHALL have port clk_i, input, 1: single clock; all state updates on rising edge.
REQ-002 SHALL have port rst_ni, input, 1: reset, asynchronous, active-low.
REQ-003 SHALL have port in_valid_i, input, 1: 32-bit RV32I instruction offered.
REQ-004 SHALL have port in_instr_i, input, 32: instruction offered.
REQ-005 SHALL have port in_ready_o, output, 1: instruction accepted when in_valid_i && in_ready_o.
REQ-006 SHALL have port flush_i, input, 1: level request to emit any held half-word.
REQ-007 SHALL have port out_valid_o, output, 1: packed 32-bit code word available.
REQ-008 SHALL have port out_word_o, output, 32: packed code word; bits [15:0] are the earlier parcel.
REQ-009 SHALL have port out_ready_i, input, 1: consumer takes the word when out_valid_o && out_ready_i.
REQ-010 SHALL have port idle_o, output, 1: no held half and no pending output.
REQ-011 SHALL have port count_o, output, 16: number of instructions compressed, saturating at 0xFFFF.

Function
REQ-012 SHALL compress, in this priority, each accepted instruction to 16 bits when its condition holds:
- LW rd,imm(x2), rd!=0, imm[1:0]=0, 0<=imm<=252 -> C.LWSP
- SW rs2,imm(x2), imm[1:0]=0, 0<=imm<=252 -> C.SWSP
- LW/SW with rd/rs2 and rs1 in x8..x15, imm[1:0]=0, 0<=imm<=124 -> C.LW/C.SW
- JAL rd=x0/x1, offset in [-2048,2046] -> C.J/C.JAL
- JALR rd=x0/x1, rs1!=0, imm=0 -> C.JR/C.JALR
- BEQ/BNE rs2=x0, rs1 in x8..x15, offset in [-256,254] -> C.BEQZ/C.BNEZ
REQ-013 SHALL use the standard RVC bit encodings for the forms in REQ-012.
REQ-014 SHALL pass every other instruction through as 32 bits unchanged, including those with in_instr_i[1:0]!=2'b11.
REQ-015 SHALL keep a 16-bit hold register, with state EMPTY or HALF.
REQ-016 SHALL, for an accepted instruction c, apply these transitions:
- EMPTY+16b -> hold c, go to HALF, no output
- EMPTY+32b -> emit c, stay EMPTY
- HALF+16b -> emit {c,held}, go to EMPTY
- HALF+32b -> emit {c[15:0],held}, hold c[31:16], stay HALF
REQ-017 SHALL drive in_ready_o = !flush_i && (!out_valid_o || out_ready_i), combinational.
REQ-018 SHALL register out_valid_o/out_word_o the cycle after acceptance, giving 1-cycle latency.
REQ-019 SHALL hold out_word_o stable while out_valid_o && !out_ready_i.
REQ-020 SHALL, when flush_i is high in HALF with the output slot free or draining, emit {16'h0001 (C.NOP), held} and go to EMPTY.
REQ-021 SHALL treat flush_i in EMPTY as a no-op.
REQ-022 SHALL, because in_ready_o is low during flush_i, never accept input and flush in the same cycle.
REQ-023 SHALL increment count_o by 1 per compressed accepted instruction and stop at 0xFFFF.
REQ-024 SHALL drive idle_o = (state==EMPTY) && !out_valid_o.

Reset
REQ-025 SHALL, while rst_ni=0, force state=EMPTY, hold=0, out_valid_o=0, out_word_o=0, count_o=0, and thereby idle_o=1.
REQ-026 SHALL, on reset mid-operation, discard any held half-word and pending output without emitting them.

Verification
REQ-027 SHALL cover: from EMPTY, feed 0x0044A403 then 0x00008067 -> one word 0x808240C0, count_o=2, idle_o=1 after drain.
REQ-028 SHALL cover: from EMPTY, feed 0x003100B3 -> out_word_o=0x003100B3 one cycle later, count_o unchanged.
REQ-029 SHALL cover: feed 0x0044A403 then 0x003100B3 -> 0x00B340C0; then assert flush_i -> 0x00010031, then idle_o=1.
REQ-030 SHALL cover: out_ready_i=0 for 5 cycles with a word pending -> out_word_o stable, in_ready_o=0, no input lost, correct words after release.
REQ-031 SHALL cover: rst_ni low while HALF -> all outputs at reset values, no stale half emitted after release.
REQ-032 SHALL cover boundaries: lw x0,0(x2), lw x8,128(x9), beq x8,x0,+256 -> all pass uncompressed; beq x8,x0,-256 -> compressed (C.BEQZ).
